// File: rtl/cache_sequencer.sv
// Trace-driven cache controller sequencer: accepts trace commands, steps lookup/write-back/fill/commit
// and keeps saturating hit/miss/read/write statistics.
module cache_sequencer #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_n,
    input  logic [31:0]      cmd_addr,
    output logic [3:0]       cur_n,
    output logic [31:0]      cur_addr,
    output logic             cache_sel,
    output logic             lkp_req,
    input  logic             lkp_done,
    input  logic             lkp_hit,
    input  logic             lkp_dirty,
    output logic             l2_req,
    output logic [1:0]       l2_op,
    input  logic             l2_ack,
    output logic             upd_en,
    output logic             clr_en,
    output logic             busy,
    output logic [CNT_W-1:0] read_cnt,
    output logic [CNT_W-1:0] write_cnt,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StWaitLkp,
        StWriteback,
        StFill,
        StCommit,
        StClear
    } state_e;

    localparam logic [1:0] OpRead = 2'b00;
    localparam logic [1:0] OpWb   = 2'b01;
    localparam logic [1:0] OpRfo  = 2'b10;

    state_e state;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Writes fetch the line for ownership; reads and fetches take a shared copy.
    function automatic logic [1:0] fill_op(input logic [3:0] n);
        return (n == 4'd1) ? OpRfo : OpRead;
    endfunction

    assign cmd_ready = (state == StIdle) && !rst;
    assign busy      = (state != StIdle);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            cur_n     <= '0;
            cur_addr  <= '0;
            cache_sel <= 1'b0;
            lkp_req   <= 1'b0;
            l2_req    <= 1'b0;
            l2_op     <= OpRead;
            upd_en    <= 1'b0;
            clr_en    <= 1'b0;
            read_cnt  <= '0;
            write_cnt <= '0;
            hit_cnt   <= '0;
            miss_cnt  <= '0;
        end else begin
            lkp_req <= 1'b0;
            upd_en  <= 1'b0;
            clr_en  <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (cmd_valid) begin
                        cur_n     <= cmd_n;
                        cur_addr  <= cmd_addr;
                        cache_sel <= (cmd_n == 4'd2);
                        if (cmd_n <= 4'd4) begin
                            state   <= StLookup;
                            lkp_req <= 1'b1;
                        end else if (cmd_n == 4'd8) begin
                            state  <= StClear;
                            clr_en <= 1'b1;
                        end
                        if (cmd_n == 4'd0 || cmd_n == 4'd2) read_cnt <= sat_inc(read_cnt);
                        if (cmd_n == 4'd1) write_cnt <= sat_inc(write_cnt);
                    end
                end
                StLookup: state <= StWaitLkp;
                StWaitLkp: begin
                    if (lkp_done) begin
                        if (cur_n <= 4'd2) begin
                            if (lkp_hit) hit_cnt <= sat_inc(hit_cnt);
                            else         miss_cnt <= sat_inc(miss_cnt);
                        end
                        // Invalidates and snoops never touch L2, hit or miss.
                        if (cur_n >= 4'd3 || lkp_hit) begin
                            state  <= StCommit;
                            upd_en <= 1'b1;
                        end else if (lkp_dirty) begin
                            state  <= StWriteback;
                            l2_req <= 1'b1;
                            l2_op  <= OpWb;
                        end else begin
                            state  <= StFill;
                            l2_req <= 1'b1;
                            l2_op  <= fill_op(cur_n);
                        end
                    end
                end
                StWriteback: begin
                    if (l2_ack) begin
                        state <= StFill;
                        l2_op <= fill_op(cur_n);
                    end
                end
                StFill: begin
                    if (l2_ack) begin
                        state  <= StCommit;
                        l2_req <= 1'b0;
                        l2_op  <= OpRead;
                        upd_en <= 1'b1;
                    end
                end
                StCommit: state <= StIdle;
                StClear: begin
                    state     <= StIdle;
                    read_cnt  <= '0;
                    write_cnt <= '0;
                    hit_cnt   <= '0;
                    miss_cnt  <= '0;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_sequencer.sv
// Bench for cache_sequencer: acts as cache datapath and L2, checks each command against a
// transaction-level model of latency, strobes, L2 phases and statistics.
module tb_cache_sequencer;

    localparam int CNT_W = 4;
    localparam int MAXV  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_n;
    logic [31:0]      cmd_addr;
    logic [3:0]       cur_n;
    logic [31:0]      cur_addr;
    logic             cache_sel;
    logic             lkp_req;
    logic             lkp_done;
    logic             lkp_hit;
    logic             lkp_dirty;
    logic             l2_req;
    logic [1:0]       l2_op;
    logic             l2_ack;
    logic             upd_en;
    logic             clr_en;
    logic             busy;
    logic [CNT_W-1:0] read_cnt;
    logic [CNT_W-1:0] write_cnt;
    logic [CNT_W-1:0] hit_cnt;
    logic [CNT_W-1:0] miss_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int m_rd = 0, m_wr = 0, m_hit = 0, m_miss = 0;

    cache_sequencer #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_n     (cmd_n),
        .cmd_addr  (cmd_addr),
        .cur_n     (cur_n),
        .cur_addr  (cur_addr),
        .cache_sel (cache_sel),
        .lkp_req   (lkp_req),
        .lkp_done  (lkp_done),
        .lkp_hit   (lkp_hit),
        .lkp_dirty (lkp_dirty),
        .l2_req    (l2_req),
        .l2_op     (l2_op),
        .l2_ack    (l2_ack),
        .upd_en    (upd_en),
        .clr_en    (clr_en),
        .busy      (busy),
        .read_cnt  (read_cnt),
        .write_cnt (write_cnt),
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v >= MAXV) ? MAXV : v + 1;
    endfunction

    task automatic check_counters(input string tag);
        check({tag, "_read_cnt"}, 64'(read_cnt), 64'(m_rd));
        check({tag, "_write_cnt"}, 64'(write_cnt), 64'(m_wr));
        check({tag, "_hit_cnt"}, 64'(hit_cnt), 64'(m_hit));
        check({tag, "_miss_cnt"}, 64'(miss_cnt), 64'(m_miss));
    endtask

    // Called at a negedge with the sequencer idle; returns at the negedge it is idle again.
    task automatic run_cmd(input string tag, input logic [3:0] n, input logic [31:0] addr,
                           input int d, input bit hit, input bit dirty, input int a1,
                           input int a2);
        int cyc = 0, lkp_cyc = 0, lkp_n = 0, upd_n = 0, clr_n = 0;
        int wb_c = 0, fill_c = 0, bad_c = 0, ph = 0, exp_lat, exp_wb, exp_fill;
        bit prev_req = 1'b0, done = 1'b0, is_lkp, miss_l2;
        logic [1:0] prev_op = 2'b00, fop;

        is_lkp   = (n <= 4);
        miss_l2  = (n <= 2) && !hit;
        fop      = (n == 1) ? 2'b10 : 2'b00;
        exp_wb   = (miss_l2 && dirty) ? a1 : 0;
        exp_fill = miss_l2 ? a2 : 0;
        exp_lat  = is_lkp ? 3 + d + exp_wb + exp_fill : ((n == 8) ? 2 : 1);

        if (n == 0 || n == 2) m_rd = sat(m_rd);
        if (n == 1) m_wr = sat(m_wr);
        if (n <= 2) begin
            if (hit) m_hit = sat(m_hit);
            else     m_miss = sat(m_miss);
        end
        if (n == 8) begin
            m_rd = 0; m_wr = 0; m_hit = 0; m_miss = 0;
        end

        check({tag, "_ready_in"}, 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1;
        cmd_n     = n;
        cmd_addr  = addr;
        lkp_done  = 1'($urandom);
        lkp_hit   = 1'($urandom);
        lkp_dirty = 1'($urandom);
        l2_ack    = 1'($urandom);

        while (!done) begin
            @(negedge clk);
            cyc++;
            cmd_valid = 1'b0;
            cmd_n     = 4'($urandom);
            cmd_addr  = $urandom;
            if (lkp_req) begin
                lkp_n++;
                if (lkp_cyc == 0) lkp_cyc = cyc;
            end
            if (upd_en) upd_n++;
            if (clr_en) clr_n++;
            if (l2_req) begin
                if (!prev_req || l2_op != prev_op) ph = 0;
                ph++;
                if (l2_op == 2'b01)    wb_c++;
                else if (l2_op == fop) fill_c++;
                else                   bad_c++;
                l2_ack = (ph == ((l2_op == 2'b01) ? a1 : a2));
            end else begin
                l2_ack = 1'($urandom);
            end
            prev_req = l2_req;
            prev_op  = l2_op;
            if (lkp_cyc != 0 && cyc == lkp_cyc + d) begin
                lkp_done = 1'b1; lkp_hit = hit; lkp_dirty = dirty;
            end else if (lkp_cyc != 0 && cyc > lkp_cyc && cyc < lkp_cyc + d) begin
                lkp_done = 1'b0; lkp_hit = 1'($urandom); lkp_dirty = 1'($urandom);
            end else begin
                lkp_done = 1'($urandom); lkp_hit = 1'($urandom); lkp_dirty = 1'($urandom);
            end
            if (cmd_ready || cyc >= 200) done = 1'b1;
        end

        check({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
        check({tag, "_lkp_req"}, 64'(lkp_n), 64'(is_lkp ? 1 : 0));
        check({tag, "_upd_en"}, 64'(upd_n), 64'(is_lkp ? 1 : 0));
        check({tag, "_clr_en"}, 64'(clr_n), 64'((n == 8) ? 1 : 0));
        check({tag, "_wb_cycles"}, 64'(wb_c), 64'(exp_wb));
        check({tag, "_fill_cycles"}, 64'(fill_c), 64'(exp_fill));
        check({tag, "_bad_l2_op"}, 64'(bad_c), 64'd0);
        check({tag, "_cur_n"}, 64'(cur_n), 64'(n));
        check({tag, "_cur_addr"}, 64'(cur_addr), 64'(addr));
        check({tag, "_cache_sel"}, 64'(cache_sel), 64'((n == 2) ? 1 : 0));
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check_counters(tag);
    endtask

    initial begin
        logic [3:0] ops [10];
        logic [3:0] rn;
        ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd1, 4'd2, 4'd8, 4'd9};

        rst = 1'b1; cmd_valid = 1'b0; cmd_n = '0; cmd_addr = '0;
        lkp_done = 1'b0; lkp_hit = 1'b0; lkp_dirty = 1'b0; l2_ack = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", 64'(cmd_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_l2_req", 64'(l2_req), 64'd0);
        check("rst_upd_en", 64'(upd_en), 64'd0);
        check_counters("rst");
        rst = 1'b0;
        @(negedge clk);

        run_cmd("read_hit", 4'd0, 32'h0000_1000, 1, 1'b1, 1'b0, 1, 1);
        run_cmd("write_miss_dirty", 4'd1, 32'h0000_2040, 1, 1'b0, 1'b1, 3, 3);
        run_cmd("fetch_miss_clean", 4'd2, 32'h0000_3080, 2, 1'b0, 1'b0, 2, 2);
        run_cmd("snoop_miss", 4'd4, 32'h0000_40c0, 1, 1'b0, 1'b1, 1, 1);
        run_cmd("inval_hit", 4'd3, 32'h0000_5000, 3, 1'b1, 1'b0, 1, 1);
        run_cmd("ack_first_cycle", 4'd1, 32'h0000_6000, 1, 1'b0, 1'b1, 1, 1);
        run_cmd("print_discard", 4'd9, 32'h0000_7000, 1, 1'b0, 1'b0, 1, 1);
        run_cmd("unknown_discard", 4'd13, 32'h0000_8000, 1, 1'b0, 1'b0, 1, 1);

        for (int i = 0; i < MAXV + 3; i++)
            run_cmd("sat_hit", 4'd0, $urandom, 1, 1'b1, 1'b0, 1, 1);
        for (int i = 0; i < MAXV + 2; i++)
            run_cmd("sat_write", 4'd1, $urandom, 1, 1'b0, 1'b0, 1, 1);
        run_cmd("clear", 4'd8, 32'h0000_9000, 1, 1'b0, 1'b0, 1, 1);

        for (int i = 0; i < 80; i++) begin
            rn = ops[$urandom_range(0, 9)];
            if ($urandom_range(0, 9) == 0) rn = 4'($urandom_range(5, 15));
            run_cmd("rand", rn, $urandom, $urandom_range(1, 4), 1'($urandom), 1'($urandom),
                    $urandom_range(1, 4), $urandom_range(1, 4));
        end

        // Reset while a fill is outstanding.
        cmd_valid = 1'b1; cmd_n = 4'd0; cmd_addr = 32'h0000_a000;
        lkp_done = 1'b0; l2_ack = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        lkp_done = 1'b1; lkp_hit = 1'b0; lkp_dirty = 1'b0;
        @(negedge clk);
        lkp_done = 1'b0;
        check("rstfill_l2_req_before", 64'(l2_req), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        m_rd = 0; m_wr = 0; m_hit = 0; m_miss = 0;
        check("rstfill_l2_req", 64'(l2_req), 64'd0);
        check("rstfill_busy", 64'(busy), 64'd0);
        check("rstfill_ready_in_rst", 64'(cmd_ready), 64'd0);
        check("rstfill_cur_addr", 64'(cur_addr), 64'd0);
        check_counters("rstfill");
        rst = 1'b0;
        l2_ack = 1'b1;
        repeat (2) @(negedge clk);
        l2_ack = 1'b0;
        check("late_ack_l2_req", 64'(l2_req), 64'd0);
        check("late_ack_busy", 64'(busy), 64'd0);
        check("late_ack_ready", 64'(cmd_ready), 64'd1);
        check("late_ack_upd_en", 64'(upd_en), 64'd0);
        run_cmd("after_rst", 4'd2, 32'h0000_b000, 1, 1'b1, 1'b0, 1, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
